// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: checker states, LFSR step (taps 15^14), preamble/LFSR sizes.
// Combinational helpers only; no latency and no flow control.
package prbs_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PATTERN = 2'd1,
        PRBS    = 2'd2
    } state_e;

    localparam int PAT_BYTES = 4;
    localparam int LFSR_W    = 16;

    function automatic logic [LFSR_W-1:0] prbs_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[14] ^ s[15]};
    endfunction

endpackage

// File: rtl/prbs_lfsr16.sv
// 16-bit PRBS LFSR: load has priority over advance, and the new state is visible the next cycle.
// It has no flow control; the caller asserts advance once per accepted byte.
module prbs_lfsr16
    import prbs_pkg::*;
(
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              advance,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = seed;
        end else if (advance) begin
            state_d = prbs_next(state_q);
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/prbs_checker.sv
// PRBS receive checker: hunts for the preamble, verifies n repeats, then checks the byte-wide PRBS.
// All outputs are registered (one cycle after the sampled byte); valid=0 stalls everything.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int LOSS_LIMIT = 4
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic [7:0]       n,
    input  logic [31:0]      in,
    input  logic [7:0]       data_in,
    input  logic             valid,
    output logic             locked,
    output logic             pattern_ok,
    output logic             err,
    output logic [CNT_W-1:0] err_count,
    output logic             lock_lost
);

    localparam logic [1:0] LAST_IDX = 2'(PAT_BYTES - 1);
    localparam logic [7:0] LOSS_LIM = 8'(LOSS_LIMIT);

    state_e            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [7:0]        rep_q, rep_d;
    logic [7:0]        n_q, n_d;
    logic [31:0]       pat_q, pat_d;
    logic              pat_err_q, pat_err_d;
    logic              pattern_ok_q, pattern_ok_d;
    logic              err_q, err_d;
    logic              lock_lost_q, lock_lost_d;
    logic [CNT_W-1:0]  err_count_q, err_count_d;
    logic [7:0]        consec_q, consec_d;

    logic              lfsr_load;
    logic              lfsr_adv;
    logic [LFSR_W-1:0] lfsr_state;
    logic              mismatch;
    logic [7:0]        consec_inc;
    logic [CNT_W-1:0]  err_count_inc;

    prbs_lfsr16 u_lfsr (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .load    (lfsr_load),
        .seed    (pat_q[LFSR_W-1:0]),
        .advance (lfsr_adv),
        .state   (lfsr_state)
    );

    assign consec_inc    = consec_q + 8'd1;
    assign err_count_inc = (err_count_q == {CNT_W{1'b1}}) ? err_count_q
                         : err_count_q + {{(CNT_W-1){1'b0}}, 1'b1};

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        rep_d        = rep_q;
        n_d          = n_q;
        pat_d        = pat_q;
        pat_err_d    = pat_err_q;
        pattern_ok_d = pattern_ok_q;
        err_d        = 1'b0;
        lock_lost_d  = 1'b0;
        err_count_d  = err_count_q;
        consec_d     = consec_q;
        lfsr_load    = 1'b0;
        lfsr_adv     = 1'b0;
        mismatch     = 1'b0;

        if (valid) begin
            unique case (state_q)
                HUNT: begin
                    if (data_in == in[7:0]) begin
                        n_d          = n;
                        pat_d        = in;
                        idx_d        = 2'd1;
                        rep_d        = 8'd0;
                        pat_err_d    = 1'b0;
                        pattern_ok_d = 1'b0;
                        state_d      = PATTERN;
                    end
                end
                PATTERN: begin
                    mismatch = (data_in != pat_q[8*idx_q +: 8]);
                    if (mismatch) begin
                        err_d       = 1'b1;
                        err_count_d = err_count_inc;
                        pat_err_d   = 1'b1;
                    end
                    if (idx_q == LAST_IDX) begin
                        // n_q of 0 wraps to 255 here, giving 256 repeats
                        if (rep_q == n_q - 8'd1) begin
                            state_d      = PRBS;
                            lfsr_load    = 1'b1;
                            consec_d     = 8'd0;
                            pattern_ok_d = !(pat_err_q || mismatch);
                        end else begin
                            rep_d = rep_q + 8'd1;
                            idx_d = 2'd0;
                        end
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
                PRBS: begin
                    lfsr_adv = 1'b1;
                    mismatch = (data_in != lfsr_state[7:0]);
                    if (mismatch) begin
                        err_d       = 1'b1;
                        err_count_d = err_count_inc;
                        if (consec_inc == LOSS_LIM) begin
                            state_d     = HUNT;
                            lock_lost_d = 1'b1;
                            consec_d    = 8'd0;
                        end else begin
                            consec_d = consec_inc;
                        end
                    end else begin
                        consec_d = 8'd0;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q      <= HUNT;
            idx_q        <= '0;
            rep_q        <= '0;
            n_q          <= '0;
            pat_q        <= '0;
            pat_err_q    <= 1'b0;
            pattern_ok_q <= 1'b0;
            err_q        <= 1'b0;
            lock_lost_q  <= 1'b0;
            err_count_q  <= '0;
            consec_q     <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            rep_q        <= rep_d;
            n_q          <= n_d;
            pat_q        <= pat_d;
            pat_err_q    <= pat_err_d;
            pattern_ok_q <= pattern_ok_d;
            err_q        <= err_d;
            lock_lost_q  <= lock_lost_d;
            err_count_q  <= err_count_d;
            consec_q     <= consec_d;
        end
    end

    assign locked     = (state_q == PRBS);
    assign pattern_ok = pattern_ok_q;
    assign err        = err_q;
    assign err_count  = err_count_q;
    assign lock_lost  = lock_lost_q;

endmodule

// File: doc/prbs_checker.md
# prbs_checker

Receive-side companion to the team's byte-wide PRBS generator. It hunts for the generator's 32-bit preamble, checks the preamble repeated `n` times, then seeds its own 16-bit LFSR and checks every later byte against the PRBS sequence. It reports lock state, pattern status, a per-byte error pulse and a saturating error count, and sits at the sink end of the link under test.

## Interface
Parameters:
- `CNT_W`, 16, width of `err_count`
- `LOSS_LIMIT`, 4, consecutive PRBS mismatches that drop lock (1..255)

Ports (one clock; reset is asynchronous and active-low):
- `CLK` input 1: clock; all state updates on the rising edge.
- `RSTn` input 1: asynchronous active-low reset.
- `n` input 8: preamble repeat count; 0 means 256.
- `in` input 32: expected preamble. Its low 16 bits are the LFSR seed.
- `data_in` input 8: received byte.
- `valid` input 1: `data_in` is sampled on edges where `valid`=1.
- `locked` output 1: high while in state PRBS.
- `pattern_ok` output 1: sticky; last preamble completed with zero mismatches.
- `err` output 1: one-cycle pulse per mismatched byte.
- `err_count` output CNT_W: mismatched bytes, saturating.
- `lock_lost` output 1: one-cycle pulse when PRBS lock is dropped.

## Operation
- Reset: state=HUNT, all outputs 0, internal counters 0, lfsr=0.
- Edges with `valid`=0 change nothing except that `err` and `lock_lost` deassert.
- **HUNT**:
  - If `data_in`==`in[7:0]`: latch `n` and `in` into `n_q` and `pat_q`, set `idx`=1, `rep`=0, clear the pattern-error flag, set `pattern_ok`=0, and go to PATTERN.
  - Otherwise stay. Bytes in HUNT are never counted as errors.
- **PATTERN**:
  - Expected byte = `pat_q[8*idx +: 8]`. A mismatch pulses `err`, increments `err_count` and sets the pattern-error flag.
  - `idx` counts 0..3. At `idx`=3:
    - If `rep`==`n_q`-1 (8-bit arithmetic, so `n_q`=0 gives 256 repeats): go to PRBS, load `lfsr`=`pat_q[15:0]`, and set `pattern_ok` = no mismatch in the whole preamble, including this byte.
    - Otherwise `rep`++ and `idx`=0.
- **PRBS**:
  - Expected byte = `lfsr[7:0]`. Every valid edge advances `lfsr` <= {`lfsr[14:0]`, `lfsr[14]`^`lfsr[15]`}, one bit per byte.
  - Mismatch: pulse `err`, increment `err_count`, increment `consec`. When `consec` reaches LOSS_LIMIT: go to HUNT, pulse `lock_lost`, clear `consec`.
  - Match: clear `consec`.
- `err_count` holds at all-ones once saturated and clears only on reset.
- `pattern_ok` keeps its value through PRBS and is cleared on re-entry to PATTERN.
- Changes on `n` or `in` after capture take effect only at the next HUNT exit.

## Timing
- All outputs are registered. `err`, `lock_lost`, `locked` and `err_count` update on the same edge that samples the offending or deciding byte, so they are visible in the following cycle.
- The first PRBS byte is compared against the seed itself.
- With `valid` held high, the PRBS check of byte k starts exactly 4·n_eff bytes after the HUNT-hit byte, where n_eff is `n` with 0 read as 256.
- `RSTn` asserted mid-operation returns everything to reset values immediately. After release, the block re-hunts.

## Structure
- `prbs_pkg` holds:
  - the state enum {HUNT, PATTERN, PRBS};
  - the function `prbs_next(logic [15:0])` with taps 15^14, shared with the generator;
  - the constants `PAT_BYTES`=4 and `LFSR_W`=16.
- One sub-module, `prbs_lfsr16`, with inputs load/seed/advance and output state. The control FSM and counters stay in `prbs_checker`.

## Test plan
- **Clean run:** `in`=32'hDEADBEEF, `n`=2, stream EF BE AD DE EF BE AD DE EF DF BF … → `pattern_ok`=1, `locked`=1 after the 8th byte, `err` never pulses, `err_count`=0.
- **Preamble corruption:** same setup, 3rd byte sent as 00 → exactly one `err` pulse, `err_count`=1, `pattern_ok`=0, lock still reached.
- **Stall and garbage:** `valid` toggled 50% and garbage 12 34 sent before the first EF → garbage is ignored, result identical to the clean run.
- **Loss of lock:** LOSS_LIMIT=4, four wrong PRBS bytes in a row → `err_count`+=4, `lock_lost` pulses once, `locked`=0, state HUNT. Three wrong bytes then one good byte keeps lock.
- **Wrap and reset:** `n`=0 → PRBS entered after 1024 preamble bytes. `CNT_W`=4 with 20 errors → `err_count`=15. Asserting `RSTn` mid-PRBS → all outputs 0.
